puck_physics: RTL

- Owns the air-hockey puck. Replaces the free-running puck mover feeding the VGA renderer.
- Once per 30 Hz cursor tick: advances the puck, bounces it off the rink walls and off both mallets, and detects goals.
- Consumes mallet positions from the two joystick updaters.
- Produces puck_x/puck_y, in the same hc/vc screen coordinates the renderer uses, plus the scores.

---
 rtl/puck_physics.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/puck_physics.sv
// puck_physics: air-hockey puck mover with wall/mallet bounces, goals and scoring,
// stepped once per rising edge of the 30 Hz cursor clock through a 4-stage pipeline.
module puck_physics #(
  parameter int X_MIN       = 194,
  parameter int X_MAX       = 736,
  parameter int Y_MIN       = 71,
  parameter int Y_MAX       = 472,
  parameter int GOAL_Y_LO   = 222,
  parameter int GOAL_Y_HI   = 321,
  parameter int PUCK_R      = 10,
  parameter int HIT_D2      = 625,
  parameter int SPEED_INIT  = 3,
  parameter int SPEED_MAX   = 7,
  parameter int PAUSE_TICKS = 60,
  parameter int SCORE_WIN   = 7
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rst,
  input  logic       clk_cursor,
  input  logic [9:0] dot_x_1,
  input  logic [9:0] dot_y_1,
  input  logic [9:0] dot_x_2,
  input  logic [9:0] dot_y_2,
  output logic [9:0] puck_x,
  output logic [9:0] puck_y,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic       goal_pulse,
  output logic       game_over,
  output logic [1:0] state
);
  typedef enum logic [1:0] {SERVE, PLAY, PAUSE, OVER} state_t;
  localparam logic signed [10:0] XL  = 11'(X_MIN + PUCK_R);
  localparam logic signed [10:0] XR  = 11'(X_MAX - PUCK_R);
  localparam logic signed [10:0] YT  = 11'(Y_MIN + PUCK_R);
  localparam logic signed [10:0] YB  = 11'(Y_MAX - PUCK_R);
  localparam logic signed [10:0] GLO = 11'(GOAL_Y_LO);
  localparam logic signed [10:0] GHI = 11'(GOAL_Y_HI);
  localparam logic [9:0] XC = 10'((X_MIN + X_MAX) / 2);
  localparam logic [9:0] YC = 10'((Y_MIN + Y_MAX) / 2);
  state_t st;
  logic cur, prev, tick;
  logic dir_x, dir_y;
  logic [2:0] speed;
  logic [5:0] pause_cnt;
  logic v1, v2, v3;
  logic signed [10:0] nx1, ny1, nx2, ny2;
  logic [9:0] nx3, ny3;
  logic dx2, dy2, g2, gr2, dx3, dy3, g3, gr3;
  logic [2:0] sp3;
  logic signed [10:0] px, py, spd;
  logic signed [10:0] ny_w, nx_w;
  logic dy_w, dx_w, left, right, mouth;
  logic signed [10:0] e1x, e1y, e2x, e2y, ex, ey;
  logic hit1, hit2, hit, dx_m, dy_m;
  logic [2:0] sp_m;
  logic [3:0] s1n, s2n, sn;
  function automatic logic [21:0] dist2(input logic signed [10:0] a, input logic signed [10:0] b);
    logic signed [21:0] a2, b2;
    a2 = 22'(a);
    b2 = 22'(b);
    return a2 * a2 + b2 * b2;
  endfunction
  assign tick  = cur & ~prev;
  assign state = st;
  assign px    = {1'b0, puck_x};
  assign py    = {1'b0, puck_y};
  assign spd   = {8'b0, speed};
  // walls: vertical clamp first, so the goal-mouth test sees the clamped row
  assign ny_w  = ny1 <= YT ? YT : ny1 >= YB ? YB : ny1;
  assign dy_w  = ny1 <= YT ? 1'b1 : ny1 >= YB ? 1'b0 : dir_y;
  assign left  = nx1 <= XL;
  assign right = nx1 >= XR;
  assign mouth = ny_w >= GLO && ny_w <= GHI;
  assign nx_w  = left ? XL : right ? XR : nx1;
  assign dx_w  = left ? 1'b1 : right ? 1'b0 : dir_x;
  // mallets: mallet 1 wins when both touch; a zero offset reverses that axis
  assign e1x   = nx2 - $signed({1'b0, dot_x_1});
  assign e1y   = ny2 - $signed({1'b0, dot_y_1});
  assign e2x   = nx2 - $signed({1'b0, dot_x_2});
  assign e2y   = ny2 - $signed({1'b0, dot_y_2});
  assign hit1  = dist2(e1x, e1y) < 22'(HIT_D2);
  assign hit2  = dist2(e2x, e2y) < 22'(HIT_D2);
  assign hit   = hit1 | hit2;
  assign ex    = hit1 ? e1x : e2x;
  assign ey    = hit1 ? e1y : e2y;
  assign dx_m  = !hit ? dx2 : ex == 11'sd0 ? ~dx2 : ~ex[10];
  assign dy_m  = !hit ? dy2 : ey == 11'sd0 ? ~dy2 : ~ey[10];
  assign sp_m  = hit && speed < 3'(SPEED_MAX) ? speed + 3'd1 : speed;
  assign s1n   = score_1 + 4'(score_1 != 4'hF);
  assign s2n   = score_2 + 4'(score_2 != 4'hF);
  assign sn    = gr3 ? s1n : s2n;
  always_ff @(posedge clk) begin
    cur  <= clk_cursor;
    prev <= cur;
    nx1  <= dir_x ? px + spd : px - spd;
    ny1  <= dir_y ? py + spd : py - spd;
    nx2  <= nx_w;
    ny2  <= ny_w;
    dx2  <= dx_w;
    dy2  <= dy_w;
    g2   <= (left | right) & mouth;
    gr2  <= right;
    nx3  <= nx2[9:0];
    ny3  <= ny2[9:0];
    dx3  <= dx_m;
    dy3  <= dy_m;
    sp3  <= sp_m;
    g3   <= g2;
    gr3  <= gr2;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr || rst) begin
      puck_x     <= XC;
      puck_y     <= YC;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      speed      <= 3'(SPEED_INIT);
      score_1    <= '0;
      score_2    <= '0;
      goal_pulse <= 1'b0;
      game_over  <= 1'b0;
      pause_cnt  <= '0;
      st         <= SERVE;
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
    end else begin
      goal_pulse <= 1'b0;
      v1 <= tick && st == PLAY;
      v2 <= v1;
      v3 <= v2;
      if (tick && st == SERVE) st <= PLAY;
      if (tick && st == PAUSE) begin
        pause_cnt <= pause_cnt - 6'd1;
        st        <= pause_cnt == 6'd1 ? SERVE : PAUSE;
      end
      if (v3 && g3) begin
        goal_pulse <= 1'b1;
        puck_x     <= XC;
        puck_y     <= YC;
        speed      <= 3'(SPEED_INIT);
        dir_x      <= gr3;
        dir_y      <= 1'b1;
        pause_cnt  <= 6'(PAUSE_TICKS);
        score_1    <= gr3 ? s1n : score_1;
        score_2    <= gr3 ? score_2 : s2n;
        game_over  <= sn == 4'(SCORE_WIN);
        st         <= sn == 4'(SCORE_WIN) ? OVER : PAUSE;
      end else if (v3) begin
        puck_x <= nx3;
        puck_y <= ny3;
        dir_x  <= dx3;
        dir_y  <= dy3;
        speed  <= sp3;
      end
    end
endmodule
